// File: rtl/command_word_sequencer.sv
// 8259 command word decoder: ICW1-ICW4 init sequencing, OCW1-OCW3 decode, config/IMR state.
// Optional macro CASCADE_EN enables the ICW3 step, honours sngl and provides cascade_cfg.
module command_word_sequencer #(
   parameter logic [7:0] IMR_INIT = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       write_flag,
   input  logic       read_flag,
   input  logic       A0,
   input  logic [7:0] data_in,
   output logic       init_done,
   output logic       ltim,
   output logic       sngl,
   output logic       ic4,
   output logic [4:0] vector_base,
   output logic [7:0] cascade_cfg,
   output logic       aeoi,
   output logic       upm,
   output logic [7:0] imr,
   output logic       eoi_strobe,
   output logic [2:0] ocw2_cmd,
   output logic [2:0] ocw2_level,
   output logic       read_isr_sel,
   output logic       smm,
   output logic       poll_pending
);

   typedef enum logic [2:0] {
      UNINIT    = 3'd0,
      WAIT_ICW2 = 3'd1,
      WAIT_ICW3 = 3'd2,
      WAIT_ICW4 = 3'd3,
      READY     = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       ltim_q, ltim_d;
   logic       sngl_q, sngl_d;
   logic       ic4_q, ic4_d;
   logic [4:0] vector_base_q, vector_base_d;
   logic       aeoi_q, aeoi_d;
   logic       upm_q, upm_d;
   logic [7:0] imr_q, imr_d;
   logic       eoi_strobe_q, eoi_strobe_d;
   logic [2:0] ocw2_cmd_q, ocw2_cmd_d;
   logic [2:0] ocw2_level_q, ocw2_level_d;
   logic       read_isr_sel_q, read_isr_sel_d;
   logic       smm_q, smm_d;
   logic       poll_pending_q, poll_pending_d;
`ifdef CASCADE_EN
   logic [7:0] cascade_cfg_q, cascade_cfg_d;
`endif

   logic   is_icw1;
   logic   poll_set;
   state_t after_icw2;

   assign is_icw1 = write_flag && !A0 && data_in[4];

   // Where the sequence goes once ICW2 is taken, from the ICW1 bits latched earlier
   always_comb begin
      after_icw2 = ic4_q ? WAIT_ICW4 : READY;
`ifdef CASCADE_EN
      if (!sngl_q) after_icw2 = WAIT_ICW3;
`endif
   end

   always_comb begin
      state_d        = state_q;
      ltim_d         = ltim_q;
      sngl_d         = sngl_q;
      ic4_d          = ic4_q;
      vector_base_d  = vector_base_q;
      aeoi_d         = aeoi_q;
      upm_d          = upm_q;
      imr_d          = imr_q;
      eoi_strobe_d   = 1'b0;
      ocw2_cmd_d     = ocw2_cmd_q;
      ocw2_level_d   = ocw2_level_q;
      read_isr_sel_d = read_isr_sel_q;
      smm_d          = smm_q;
      poll_pending_d = poll_pending_q;
      poll_set       = 1'b0;
`ifdef CASCADE_EN
      cascade_cfg_d  = cascade_cfg_q;
`endif

      if (is_icw1) begin
         state_d        = WAIT_ICW2;
         ltim_d         = data_in[3];
`ifdef CASCADE_EN
         sngl_d         = data_in[1];
         cascade_cfg_d  = 8'h00;
`else
         sngl_d         = 1'b1;
`endif
         ic4_d          = data_in[0];
         imr_d          = IMR_INIT;
         read_isr_sel_d = 1'b0;
         smm_d          = 1'b0;
         poll_pending_d = 1'b0;
         if (!data_in[0]) begin
            aeoi_d = 1'b0;
            upm_d  = 1'b0;
         end
      end else if (write_flag) begin
         case (state_q)
            WAIT_ICW2: begin
               if (A0) begin
                  vector_base_d = data_in[7:3];
                  state_d       = after_icw2;
               end
            end
`ifdef CASCADE_EN
            WAIT_ICW3: begin
               if (A0) begin
                  cascade_cfg_d = data_in;
                  state_d       = ic4_q ? WAIT_ICW4 : READY;
               end
            end
`endif
            WAIT_ICW4: begin
               if (A0) begin
                  aeoi_d  = data_in[1];
                  upm_d   = data_in[0];
                  state_d = READY;
               end
            end
            READY: begin
               if (A0) begin
                  imr_d = data_in;
               end else if (!data_in[3]) begin
                  eoi_strobe_d = 1'b1;
                  ocw2_cmd_d   = data_in[7:5];
                  ocw2_level_d = data_in[2:0];
               end else begin
                  if (data_in[1]) read_isr_sel_d = data_in[0];
                  if (data_in[6]) smm_d = data_in[5];
                  if (data_in[2]) begin
                     poll_pending_d = 1'b1;
                     poll_set       = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      // A poll command in the same cycle as a read keeps the poll pending
      if (read_flag && !poll_set) poll_pending_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= UNINIT;
         ltim_q         <= 1'b0;
         sngl_q         <= 1'b0;
         ic4_q          <= 1'b0;
         vector_base_q  <= 5'h00;
         aeoi_q         <= 1'b0;
         upm_q          <= 1'b0;
         imr_q          <= IMR_INIT;
         eoi_strobe_q   <= 1'b0;
         ocw2_cmd_q     <= 3'b000;
         ocw2_level_q   <= 3'b000;
         read_isr_sel_q <= 1'b0;
         smm_q          <= 1'b0;
         poll_pending_q <= 1'b0;
`ifdef CASCADE_EN
         cascade_cfg_q  <= 8'h00;
`endif
      end else begin
         state_q        <= state_d;
         ltim_q         <= ltim_d;
         sngl_q         <= sngl_d;
         ic4_q          <= ic4_d;
         vector_base_q  <= vector_base_d;
         aeoi_q         <= aeoi_d;
         upm_q          <= upm_d;
         imr_q          <= imr_d;
         eoi_strobe_q   <= eoi_strobe_d;
         ocw2_cmd_q     <= ocw2_cmd_d;
         ocw2_level_q   <= ocw2_level_d;
         read_isr_sel_q <= read_isr_sel_d;
         smm_q          <= smm_d;
         poll_pending_q <= poll_pending_d;
`ifdef CASCADE_EN
         cascade_cfg_q  <= cascade_cfg_d;
`endif
      end
   end

   assign init_done    = (state_q == READY);
   assign ltim         = ltim_q;
   assign sngl         = sngl_q;
   assign ic4          = ic4_q;
   assign vector_base  = vector_base_q;
   assign aeoi         = aeoi_q;
   assign upm          = upm_q;
   assign imr          = imr_q;
   assign eoi_strobe   = eoi_strobe_q;
   assign ocw2_cmd     = ocw2_cmd_q;
   assign ocw2_level   = ocw2_level_q;
   assign read_isr_sel = read_isr_sel_q;
   assign smm          = smm_q;
   assign poll_pending = poll_pending_q;
`ifdef CASCADE_EN
   assign cascade_cfg  = cascade_cfg_q;
`else
   assign cascade_cfg  = 8'h00;
`endif

endmodule

// File: tb/tb_command_word_sequencer.sv
// Randomized bench for command_word_sequencer against a queue-based model of the ICW/OCW rules.
module tb_command_word_sequencer;
   localparam logic [7:0] IMR_INIT = 8'h00;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       write_flag = 1'b0, read_flag = 1'b0, A0 = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       init_done, ltim, sngl, ic4, aeoi, upm, eoi_strobe;
   logic       read_isr_sel, smm, poll_pending;
   logic [4:0] vector_base;
   logic [7:0] cascade_cfg, imr;
   logic [2:0] ocw2_cmd, ocw2_level;

   int vec_cnt = 0;
   int err_cnt = 0;

   command_word_sequencer #(.IMR_INIT(IMR_INIT)) dut (
      .clk(clk), .reset(reset), .write_flag(write_flag), .read_flag(read_flag),
      .A0(A0), .data_in(data_in), .init_done(init_done), .ltim(ltim), .sngl(sngl),
      .ic4(ic4), .vector_base(vector_base), .cascade_cfg(cascade_cfg), .aeoi(aeoi),
      .upm(upm), .imr(imr), .eoi_strobe(eoi_strobe), .ocw2_cmd(ocw2_cmd),
      .ocw2_level(ocw2_level), .read_isr_sel(read_isr_sel), .smm(smm),
      .poll_pending(poll_pending)
   );

   always #5 clk = ~clk;

   // Reference model: the init sequence is a queue of ICW numbers still owed
   int         m_pend[$];
   logic       m_started;
   logic       m_ltim, m_sngl, m_ic4, m_aeoi, m_upm, m_eoi, m_isr, m_smm, m_poll;
   logic [4:0] m_vb;
   logic [7:0] m_casc, m_imr;
   logic [2:0] m_cmd, m_lvl;
   logic       m_rst_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend.delete();
      m_started = 0; m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_aeoi = 0; m_upm = 0;
      m_eoi = 0; m_isr = 0; m_smm = 0; m_poll = 0; m_vb = 0; m_casc = 0;
      m_imr = IMR_INIT; m_cmd = 0; m_lvl = 0;
   endtask

   task automatic model_apply(input logic rst, input logic wf, input logic rf,
                              input logic a0, input logic [7:0] d);
      logic pset;
      pset = 0;
      m_rst_seen = rst;
      if (rst) begin
         model_reset();
         return;
      end
      m_eoi = 0;
      if (wf && !a0 && d[4]) begin
         m_started = 1;
         m_ltim = d[3];
`ifdef CASCADE_EN
         m_sngl = d[1];
`else
         m_sngl = 1;
`endif
         m_ic4 = d[0];
         m_imr = IMR_INIT; m_isr = 0; m_smm = 0; m_poll = 0; m_casc = 0;
         if (!d[0]) begin m_aeoi = 0; m_upm = 0; end
         m_pend.delete();
         m_pend.push_back(2);
         if (!m_sngl) m_pend.push_back(3);
         if (m_ic4) m_pend.push_back(4);
      end else if (wf && m_started && m_pend.size() > 0) begin
         if (a0) begin
            case (m_pend[0])
               2: m_vb = d[7:3];
               3: m_casc = d;
               default: begin m_aeoi = d[1]; m_upm = d[0]; end
            endcase
            void'(m_pend.pop_front());
         end
      end else if (wf && m_started) begin
         if (a0) m_imr = d;
         else if (!d[3]) begin
            m_eoi = 1; m_cmd = d[7:5]; m_lvl = d[2:0];
         end else begin
            if (d[1]) m_isr = d[0];
            if (d[6]) m_smm = d[5];
            if (d[2]) begin m_poll = 1; pset = 1; end
         end
      end
      if (rf && !pset) m_poll = 0;
   endtask

   task automatic compare_all();
      chk("init_done", init_done, m_started && m_pend.size() == 0);
      chk("ltim", ltim, m_ltim);
      chk("sngl", sngl, m_sngl);
      chk("ic4", ic4, m_ic4);
      chk("vector_base", vector_base, m_vb);
      chk("cascade_cfg", cascade_cfg, m_casc);
      chk("aeoi", aeoi, m_aeoi);
      chk("upm", upm, m_upm);
      chk("imr", imr, m_imr);
      chk("eoi_strobe", eoi_strobe, m_eoi);
      chk("read_isr_sel", read_isr_sel, m_isr);
      chk("smm", smm, m_smm);
      chk("poll_pending", poll_pending, m_poll);
      if (m_eoi || m_rst_seen) begin
         chk("ocw2_cmd", ocw2_cmd, m_cmd);
         chk("ocw2_level", ocw2_level, m_lvl);
      end
   endtask

   // Drive one cycle of inputs, let the edge take them, then compare against the model
   task automatic step(input logic rst, input logic wf, input logic rf,
                       input logic a0, input logic [7:0] d);
      reset = rst; write_flag = wf; read_flag = rf; A0 = a0; data_in = d;
      @(posedge clk);
      #1;
      model_apply(rst, wf, rf, a0, d);
      compare_all();
      reset = 0; write_flag = 0; read_flag = 0;
   endtask

   task automatic wr(input logic a0, input logic [7:0] d);
      step(1'b0, 1'b1, 1'b0, a0, d);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      model_reset();
      #1;
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h13);   // reset beats a write in the same cycle
      chk("rst_init_done", init_done, 1'b0);

      // UNINIT ignores non-ICW1 writes
      wr(1'b1, 8'hFF);
      chk("uninit_imr", imr, IMR_INIT);

      // Single-mode init with ICW4
      wr(1'b0, 8'h13);
      wr(1'b1, 8'h48);
      wr(1'b0, 8'h08);                        // A0=0 non-ICW1 in WAIT_ICW4: ignored
      wr(1'b1, 8'h03);
      chk("tp_init_done", init_done, 1'b1);
      chk("tp_vector_base", vector_base, 5'h09);
      chk("tp_aeoi_upm", {aeoi, upm}, 2'b11);

      // OCWs in READY, back to back
      wr(1'b1, 8'hA5);
      chk("tp_imr", imr, 8'hA5);
      wr(1'b0, 8'h63);
      chk("tp_eoi", {eoi_strobe, ocw2_cmd, ocw2_level}, {1'b1, 3'b011, 3'd3});
      wr(1'b0, 8'h0B);
      chk("tp_eoi_drop", eoi_strobe, 1'b0);
      wr(1'b0, 8'h68);
      wr(1'b0, 8'h0C);
      chk("tp_poll", poll_pending, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("tp_poll_clr", poll_pending, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h0C);   // poll set and read together: set wins
      idle();

      // Cascade sequence: 4 writes with CASCADE_EN, 3 without
      wr(1'b0, 8'h11);
      wr(1'b1, 8'h20);
      wr(1'b1, 8'h04);
`ifdef CASCADE_EN
      chk("casc_not_ready", init_done, 1'b0);
      wr(1'b1, 8'h01);
      chk("casc_cfg", cascade_cfg, 8'h04);
`else
      chk("nocasc_cfg", cascade_cfg, 8'h00);
`endif
      chk("casc_ready", init_done, 1'b1);

      // ICW1 restart from WAIT_ICW4
      wr(1'b1, 8'h5A);
      wr(1'b0, 8'h13);
      wr(1'b1, 8'h48);
      wr(1'b0, 8'h1B);
      chk("restart_init_done", init_done, 1'b0);
      chk("restart_imr", imr, IMR_INIT);

      // Reset partway through (WAIT_ICW3 when cascade is built in)
      wr(1'b0, 8'h11);
      wr(1'b1, 8'h20);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("midrst_vb", vector_base, 5'h00);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic rst, wf, rf, a0;
         logic [7:0] d;
         rst = ($urandom_range(0, 99) < 2);
         wf  = ($urandom_range(0, 3) != 0);
         rf  = ($urandom_range(0, 5) == 0);
         a0  = ($urandom_range(0, 2) != 0);
         d   = 8'($urandom);
         step(rst, wf, rf, a0, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/command_word_sequencer.md
# command_word_sequencer

Decodes the host write stream delivered by the read/write logic into 8259 initialization words (ICW1–ICW4) and operation words (OCW1–OCW3). It tracks the initialization sequence, holds the programmed configuration and interrupt mask, and issues one-cycle command strobes to the priority/ISR control stage. It sits directly downstream of the read/write logic, consuming its `write_flag`/`read_flag` pulses together with `A0` and the data bus.

## Interface

Parameters:
- `IMR_INIT`, 8'h00: value loaded into the IMR on reset and on every ICW1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `write_flag`  in  1  one-cycle pulse per host write, from read/write logic.
- `read_flag`  in  1  one-cycle pulse per host read.
- `A0`  in  1  address bit, valid while `write_flag` is high.
- `data_in`  in  8  host data, valid while `write_flag` is high.
- `init_done`  out  1  high in READY.
- `ltim`, `sngl`, `ic4`  out  1 each  ICW1 bits D3, D1, D0.
- `vector_base`  out  5  ICW2 bits D7..D3.
- `cascade_cfg`  out  8  ICW3 byte.
- `aeoi`, `upm`  out  1 each  ICW4 bits D1, D0.
- `imr`  out  8  interrupt mask register (OCW1).
- `eoi_strobe`  out  1  one-cycle pulse on an OCW2 EOI-class command.
- `ocw2_cmd`  out  3  OCW2 bits D7..D5; valid while `eoi_strobe` is high.
- `ocw2_level`  out  3  OCW2 bits D2..D0; valid while `eoi_strobe` is high.
- `read_isr_sel`  out  1  1 selects ISR, 0 selects IRR for status reads (OCW3).
- `smm`  out  1  special mask mode enable.
- `poll_pending`  out  1  set by an OCW3 poll command; cleared by the next `read_flag`.

## Operation

- States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. Decoding happens only on cycles where `write_flag`=1.
- ICW1 is `A0`=0 with `data_in[4]`=1. It is accepted in any state and moves to WAIT_ICW2. It latches `ltim`/`sngl`/`ic4`, loads `imr`=`IMR_INIT`, clears `read_isr_sel`, `smm`, `poll_pending` and `cascade_cfg`, and clears `aeoi`/`upm` when `ic4`=0.
- WAIT_ICW2: a write with `A0`=1 latches `vector_base`=`data_in[7:3]`.
  - Next state: WAIT_ICW3 if `sngl`=0, else WAIT_ICW4 if `ic4`=1, else READY.
  - A write with `A0`=0 that is not ICW1 is ignored, and the state is held.
- WAIT_ICW3: a write with `A0`=1 latches `cascade_cfg`. Next state: WAIT_ICW4 if `ic4`=1, else READY.
- WAIT_ICW4: a write with `A0`=1 latches `aeoi`/`upm`. Next state: READY.
- READY decoding:
  - `A0`=1: OCW1, `imr`=`data_in`.
  - `A0`=0, D4=0, D3=0: OCW2. Pulses `eoi_strobe` and drives `ocw2_cmd`/`ocw2_level`.
  - `A0`=0, D4=0, D3=1: OCW3.
    - D1=1: `read_isr_sel`=D0.
    - D6=1: `smm`=D5.
    - D2=1: sets `poll_pending`.
- In UNINIT, every write other than ICW1 is ignored.
- `read_flag` has no effect except clearing `poll_pending`.
- If `read_flag` and a poll OCW3 occur in the same cycle, set wins.

## Timing

- All registered outputs update on the edge where `write_flag` is sampled high and are visible the following cycle. Write-to-output latency is 1 cycle.
- `eoi_strobe` is high for exactly one cycle, the cycle after the OCW2 write. `ocw2_cmd`/`ocw2_level` are valid in that same cycle.
- Back-to-back `write_flag` pulses on consecutive cycles are each decoded; no write is dropped.
- Reset values: state UNINIT; `init_done`=0; `imr`=`IMR_INIT`; all other outputs 0.
- Reset asserted mid-sequence returns to UNINIT on the next edge. Reset overrides `write_flag` in the same cycle.
- ICW1 arriving mid-sequence restarts the sequence. `init_done` drops in the following cycle.

## Configuration

- `CASCADE_EN` defined: WAIT_ICW3 is implemented and `sngl` is honoured as described above.
- `CASCADE_EN` undefined:
  - WAIT_ICW3 is removed, and `sngl` reads 1 regardless of D1.
  - WAIT_ICW2 goes directly to WAIT_ICW4 or READY.
  - `cascade_cfg` is tied to 0.

## Test plan

- Reset, then ICW1=8'h13 (`A0`=0) and ICW2=8'h48 (`A0`=1), then ICW4=8'h03 (`A0`=1) -> `init_done`=1, `vector_base`=5'h09, `sngl`=1, `aeoi`=1, `upm`=1.
- With `CASCADE_EN`: ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h01 -> `cascade_cfg`=8'h04, READY after the 4th write. Without `CASCADE_EN`: the third write (8'h04) is taken as ICW4 and READY is reached after 3 writes.
- In READY, `A0`=1 with 8'hA5 -> `imr`=8'hA5 one cycle later. Then `A0`=0 with 8'h63 -> `eoi_strobe` pulses for 1 cycle with `ocw2_cmd`=3'b011 and `ocw2_level`=3'd3.
- OCW3 8'h0B -> `read_isr_sel`=1. OCW3 8'h68 -> `smm`=1. OCW3 8'h0C -> `poll_pending`=1, then a `read_flag` pulse -> `poll_pending`=0.
- ICW1 issued mid-sequence while in WAIT_ICW4 -> state WAIT_ICW2, `init_done`=0, `imr`=`IMR_INIT`. Reset asserted in WAIT_ICW3 -> UNINIT, all outputs at reset values the next cycle.
- In UNINIT, write `A0`=1 with 8'hFF -> `imr` unchanged and `init_done` stays 0.
